// File: rtl/huff_pkg.sv
// Shared types, constants and node-table helpers for the Huffman sequencer.
package huff_pkg;

   localparam int unsigned NODE_W    = 13;
   localparam int unsigned NODES     = 7;

   localparam int unsigned PARENT_HI = 12;
   localparam int unsigned PARENT_LO = 9;
   localparam int unsigned LR_BIT    = 8;
   localparam int unsigned WEIGHT_HI = 7;
   localparam int unsigned WEIGHT_LO = 0;

   localparam logic [3:0] ROOT_PARENT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_BUILD = 3'd2,
      ST_GEN   = 3'd3,
      ST_ENC   = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_e;

   // Parent field of node (idx+1); node 1 sits in the LSBs of the table.
   function automatic logic [3:0] parent_of(input logic [NODES*NODE_W-1:0] tbl,
                                            input int unsigned idx);
      logic [NODE_W-1:0] rec;
      rec = tbl[idx*NODE_W +: NODE_W];
      return rec[PARENT_HI:PARENT_LO];
   endfunction

   // Root must point at the sentinel parent; every other node must point inside the table.
   function automatic logic table_ok(input logic [NODES*NODE_W-1:0] tbl);
      logic ok;
      ok = (parent_of(tbl, NODES - 1) == ROOT_PARENT);
      for (int unsigned i = 0; i < NODES - 1; i++) begin
         if (parent_of(tbl, i) >= 4'(NODES)) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/huff_stage_timer.sv
// Per-stage cycle counter: cleared on stage entry, flags when it reaches the limit.
module huff_stage_timer #(
   parameter int unsigned W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: entry clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = cnt_q + W'(1);
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == limit);

endmodule

// File: rtl/huff_seq_ctrl.sv
// Top-level Huffman pipeline sequencer: count -> build -> generate -> encode.
module huff_seq_ctrl
   import huff_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned GEN_CYCLES = 16
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic                      start,
   input  logic                      abort,
   output logic                      cnt_start,
   input  logic                      cnt_done,
   output logic                      tree_start,
   input  logic                      tree_done,
   input  logic [NODES*NODE_W-1:0]   tree_nodes,
   output logic [NODES*NODE_W-1:0]   node_bus,
   output logic                      gen_nRST,
   output logic                      enc_start,
   input  logic                      enc_done,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [2:0]                stage
);

   localparam int unsigned MAXC = (TIMEOUT > GEN_CYCLES) ? TIMEOUT : GEN_CYCLES;
   localparam int unsigned TW   = (MAXC > 2) ? $clog2(MAXC) : 1;

   state_e                    state_q, state_d;
   logic                      cnt_start_q, cnt_start_d;
   logic                      tree_start_q, tree_start_d;
   logic                      enc_start_q, enc_start_d;
   logic                      gen_q, gen_d;
   logic [NODES*NODE_W-1:0]   node_q, node_d;
   logic [TW-1:0]             limit;
   logic                      expired;
   logic                      in_busy;

   assign in_busy = (state_q == ST_COUNT) || (state_q == ST_BUILD) ||
                    (state_q == ST_GEN)   || (state_q == ST_ENC);
   assign limit   = (state_q == ST_GEN) ? TW'(GEN_CYCLES - 1) : TW'(TIMEOUT - 1);

   huff_stage_timer #(.W(TW)) u_timer (
      .clk     (CLK),
      .rst_n   (nRST),
      .clr     (state_d != state_q),
      .en      (in_busy),
      .limit   (limit),
      .expired (expired)
   );

   // Next state, entry pulses, generate_code reset and node table capture.
   always_comb begin
      state_d = state_q;
      node_d  = node_q;
      gen_d   = gen_q;
      unique case (state_q)
         ST_IDLE, ST_ERR: if (start) state_d = ST_COUNT;
         ST_COUNT: begin
            if (cnt_done)     state_d = ST_BUILD;
            else if (expired) state_d = ST_ERR;
         end
         ST_BUILD: begin
            // The check runs on tree_nodes directly; it is the same value captured this edge.
            if (tree_done)    state_d = table_ok(tree_nodes) ? ST_GEN : ST_ERR;
            else if (expired) state_d = ST_ERR;
         end
         ST_GEN: if (expired) state_d = ST_ENC;
         ST_ENC: begin
            if (enc_done)     state_d = ST_DONE;
            else if (expired) state_d = ST_ERR;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;

      if (state_q == ST_BUILD && tree_done && !abort) node_d = tree_nodes;

      if (state_d == ST_GEN)                                gen_d = 1'b1;
      else if (state_d == ST_COUNT || state_d == ST_ERR || abort) gen_d = 1'b0;

      cnt_start_d  = (state_d == ST_COUNT) && (state_q != ST_COUNT);
      tree_start_d = (state_d == ST_BUILD) && (state_q != ST_BUILD);
      enc_start_d  = (state_d == ST_ENC)   && (state_q != ST_ENC);
   end

   // Sequencer registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= ST_IDLE;
         cnt_start_q  <= 1'b0;
         tree_start_q <= 1'b0;
         enc_start_q  <= 1'b0;
         gen_q        <= 1'b0;
         node_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_start_q  <= cnt_start_d;
         tree_start_q <= tree_start_d;
         enc_start_q  <= enc_start_d;
         gen_q        <= gen_d;
         node_q       <= node_d;
      end
   end

   assign cnt_start  = cnt_start_q;
   assign tree_start = tree_start_q;
   assign enc_start  = enc_start_q;
   assign gen_nRST   = gen_q;
   assign node_bus   = node_q;
   assign busy       = in_busy;
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERR);
   assign stage      = state_q;

endmodule

// File: tb/tb_huff_seq_ctrl.sv
// Self-checking bench for huff_seq_ctrl (TIMEOUT=16, GEN_CYCLES=4).
module tb_huff_seq_ctrl;
   import huff_pkg::*;

   localparam int T_OUT = 16;
   localparam int G_CYC = 4;
   localparam logic [90:0] NOM = {13'h1F77, 13'h0A44, 13'h083D, 13'h032B,
                                  13'h0222, 13'h011C, 13'h001A};
   localparam logic [90:0] BAD_ROOT = {13'h0777, 13'h0A44, 13'h083D, 13'h032B,
                                       13'h0222, 13'h011C, 13'h001A};
   localparam logic [90:0] BAD_N1 = {13'h1F77, 13'h0A44, 13'h083D, 13'h032B,
                                     13'h0222, 13'h011C, 13'h121A};

   logic        CLK = 1'b0, nRST = 1'b0, start = 1'b0, abort = 1'b0;
   logic        cnt_done = 1'b0, tree_done = 1'b0, enc_done = 1'b0;
   logic [90:0] tree_nodes = '0;
   logic [90:0] node_bus;
   logic        cnt_start, tree_start, enc_start, gen_nRST, busy, done, error;
   logic [2:0]  stage;

   int          checks = 0, failures = 0;
   logic [90:0] exp_nodes = '0;

   huff_seq_ctrl #(.TIMEOUT(T_OUT), .GEN_CYCLES(G_CYC)) dut (
      .CLK(CLK), .nRST(nRST), .start(start), .abort(abort),
      .cnt_start(cnt_start), .cnt_done(cnt_done),
      .tree_start(tree_start), .tree_done(tree_done), .tree_nodes(tree_nodes),
      .node_bus(node_bus), .gen_nRST(gen_nRST),
      .enc_start(enc_start), .enc_done(enc_done),
      .busy(busy), .done(done), .error(error), .stage(stage)
   );

   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [90:0] act, input logic [90:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected outcome of one run from its stage-entry arithmetic (t=0 is the cnt_start cycle).
   task automatic model(input int dc, input int dt, input int de, input bit ok,
                        output int end_t, output bit err, output int enc_t, output bit cap);
      int tb_s, te;
      enc_t = -1; cap = 1'b0; err = 1'b1;
      if (dc > T_OUT - 1) begin end_t = T_OUT; return; end
      tb_s = dc + 1;
      if (dt > T_OUT - 1) begin end_t = tb_s + T_OUT; return; end
      cap = 1'b1;
      if (!ok) begin end_t = tb_s + dt + 1; return; end
      te = tb_s + dt + 1 + G_CYC;
      enc_t = te;
      if (de > T_OUT - 1) end_t = te + T_OUT;
      else begin end_t = te + de + 1; err = 1'b0; end
   endtask

   // Random node table; when bad, one parent field is pushed out of range.
   task automatic make_table(input bit bad, output logic [90:0] t);
      logic [12:0] rec;
      int k;
      k = int'($urandom_range(0, 6));
      for (int i = 0; i < 7; i++) begin
         rec[7:0]  = 8'($urandom);
         rec[8]    = 1'($urandom);
         rec[12:9] = (i == 6) ? 4'hF : 4'($urandom_range(0, 6));
         if (bad && i == k)
            rec[12:9] = (i == 6) ? 4'($urandom_range(0, 14)) : 4'($urandom_range(7, 15));
         t[i*13 +: 13] = rec;
      end
   endtask

   // Issue start, answer each stage pulse after the given delay, record the outcome.
   task automatic run_case(input int dc, input int dt, input int de, input logic [90:0] tbl,
                           output int end_t, output bit err, output int enc_t, output int gen_t);
      int c0, b0, e0;
      c0 = -1; b0 = -1; e0 = -1;
      end_t = -1; err = 1'b0; enc_t = -1; gen_t = -1;
      tree_nodes = tbl;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("entry_cnt_start", cnt_start, 1);
      chk("entry_gen_nRST_low", gen_nRST, 0);
      for (int t = 0; t < 200; t++) begin
         if (cnt_start && c0 < 0) c0 = t;
         if (tree_start && b0 < 0) b0 = t;
         if (enc_start && e0 < 0) begin e0 = t; enc_t = t; end
         if (gen_nRST && gen_t < 0) gen_t = t;
         if (done)  begin end_t = t; err = 1'b0; break; end
         if (error) begin end_t = t; err = 1'b1; break; end
         cnt_done  = (c0 >= 0) && (t - c0 == dc);
         tree_done = (b0 >= 0) && (t - b0 == dt);
         enc_done  = (e0 >= 0) && (t - e0 == de);
         @(negedge CLK);
      end
      cnt_done = 1'b0; tree_done = 1'b0; enc_done = 1'b0;
   endtask

   task automatic check_run(input string tag, input int dc, input int dt, input int de,
                            input logic [90:0] tbl, input int x_end, input bit x_err,
                            input int x_enc, input bit x_cap);
      int end_t, enc_t, gen_t;
      bit err;
      run_case(dc, dt, de, tbl, end_t, err, enc_t, gen_t);
      if (x_cap) exp_nodes = tbl;
      chk({tag, "_end_cycle"}, end_t, x_end);
      chk({tag, "_is_error"}, err, x_err);
      chk({tag, "_enc_start_cycle"}, enc_t, x_enc);
      chk({tag, "_gen_rise_cycle"}, gen_t, (x_enc >= 0) ? x_enc - G_CYC : -1);
      chk({tag, "_end_gen_nRST"}, gen_nRST, !x_err);
      chk({tag, "_end_busy"}, busy, 0);
      chk({tag, "_node_bus"}, node_bus, exp_nodes);
      @(negedge CLK);
      if (!x_err) begin
         chk({tag, "_done_single"}, done, 0);
         chk({tag, "_back_idle"}, stage, 0);
         chk({tag, "_gen_kept"}, gen_nRST, 1);
      end else begin
         chk({tag, "_err_holds"}, stage, 6);
      end
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
   endtask

   typedef struct {
      int          dc, dt, de;
      logic [90:0] tbl;
      int          exp_end;
      bit          exp_err;
      int          exp_enc;
      bit          cap;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int          m_end, m_enc, cnt_bad;
      bit          m_err, m_cap, bad;
      logic [90:0] rt;

      vecs[0] = '{3,  3,  3,  NOM,      16, 1'b0, 12, 1'b1};
      vecs[1] = '{20, 0,  0,  NOM,      16, 1'b1, -1, 1'b0};
      vecs[2] = '{15, 0,  0,  NOM,      22, 1'b0, 21, 1'b1};
      vecs[3] = '{3,  3,  3,  BAD_ROOT,  8, 1'b1, -1, 1'b1};
      vecs[4] = '{0,  0,  0,  BAD_N1,    2, 1'b1, -1, 1'b1};
      vecs[5] = '{0,  0,  16, NOM,      22, 1'b1,  6, 1'b1};
      vecs[6] = '{0,  15, 15, NOM,      37, 1'b0, 21, 1'b1};
      vecs[7] = '{1,  16, 0,  NOM,      18, 1'b1, -1, 1'b0};

      // Reset state
      repeat (2) @(negedge CLK);
      chk("rst_stage", stage, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_gen_nRST", gen_nRST, 0);
      chk("rst_node_bus", node_bus, 0);
      chk("rst_starts", {cnt_start, tree_start, enc_start}, 0);
      nRST = 1'b1;
      @(negedge CLK);

      // Directed vectors
      foreach (vecs[i])
         check_run($sformatf("vec%0d", i), vecs[i].dc, vecs[i].dt, vecs[i].de, vecs[i].tbl,
                   vecs[i].exp_end, vecs[i].exp_err, vecs[i].exp_enc, vecs[i].cap);

      // Randomized runs against the arithmetic model
      for (int n = 0; n < 40; n++) begin
         int dc, dt, de;
         dc  = int'($urandom_range(0, 17));
         dt  = int'($urandom_range(0, 17));
         de  = int'($urandom_range(0, 17));
         bad = ($urandom_range(0, 3) == 0);
         make_table(bad, rt);
         model(dc, dt, de, !bad, m_end, m_err, m_enc, m_cap);
         check_run($sformatf("rnd%0d", n), dc, dt, de, rt, m_end, m_err, m_enc, m_cap);
      end
      do_abort();

      // Timeout, then restart from ERR
      check_run("tmo", 20, 0, 0, NOM, T_OUT, 1'b1, -1, 1'b0);
      chk("tmo_error", error, 1);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("restart_error_clr", error, 0);
      chk("restart_stage", stage, 1);
      chk("restart_cnt_start", cnt_start, 1);
      do_abort();
      chk("restart_abort_idle", stage, 0);

      // Abort on the second GEN cycle with an enc_done glitch
      make_table(1'b0, rt);
      tree_nodes = rt;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0; cnt_done = 1'b1;
      @(negedge CLK);
      cnt_done = 1'b0; tree_done = 1'b1;
      @(negedge CLK);
      tree_done = 1'b0;
      chk("ag_gen_entry", {stage, gen_nRST}, {3'd3, 1'b1});
      @(negedge CLK);
      abort = 1'b1; enc_done = 1'b1;
      @(negedge CLK);
      abort = 1'b0; enc_done = 1'b0;
      exp_nodes = rt;
      chk("ag_stage", stage, 0);
      chk("ag_gen_nRST", gen_nRST, 0);
      chk("ag_busy", busy, 0);
      chk("ag_node_bus", node_bus, exp_nodes);
      cnt_bad = 0;
      for (int k = 0; k < 8; k++) begin
         if (done || enc_start || stage != 3'd0) cnt_bad++;
         @(negedge CLK);
      end
      chk("ag_quiet", cnt_bad, 0);

      // abort together with cnt_done
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0; abort = 1'b1; cnt_done = 1'b1;
      @(negedge CLK);
      abort = 1'b0; cnt_done = 1'b0;
      chk("ab_cnt_stage", stage, 0);
      chk("ab_cnt_tree_start", tree_start, 0);

      // start while busy is ignored
      start = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      chk("busy_start_stage", stage, 1);
      chk("busy_start_no_pulse", cnt_start, 0);
      start = 1'b0;
      do_abort();

      // abort + start in IDLE
      abort = 1'b1; start = 1'b1;
      @(negedge CLK);
      abort = 1'b0; start = 1'b0;
      chk("ab_start_idle", {stage, cnt_start, busy}, 0);
      chk("ab_node_bus_kept", node_bus, exp_nodes);

      // Async reset during ENC
      tree_nodes = NOM;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0; cnt_done = 1'b1;
      @(negedge CLK);
      cnt_done = 1'b0; tree_done = 1'b1;
      @(negedge CLK);
      tree_done = 1'b0;
      repeat (G_CYC) @(negedge CLK);
      chk("rstenc_enc_entry", {stage, enc_start}, {3'd4, 1'b1});
      @(negedge CLK);
      #1 nRST = 1'b0;
      #1;
      chk("rstenc_stage", stage, 0);
      chk("rstenc_flags", {busy, done, error, gen_nRST}, 0);
      chk("rstenc_starts", {cnt_start, tree_start, enc_start}, 0);
      chk("rstenc_node_bus", node_bus, 0);
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
